// File: rtl/pwm_carrier_gen_pkg.sv
// ----------------------------------------------------------------------------
// pwm_carrier_gen_pkg
// Shared constants and mode encodings for the PWM carrier generator.
// Contents:
//   CNT_W / DIV_W / EVT_W    carrier, prescaler and event-decimation widths
//   count_mode_e             carrier counting style (2'b11 behaves as UP)
//   mask_mode_e              which boundary events may load shadows / count
//   onoff_e                  generic on/off switch encoding
//   modeDir()                direction rule for a given mode and position
// ----------------------------------------------------------------------------
package pwm_carrier_gen_pkg;

   localparam int CNT_W = 16;
   localparam int DIV_W = 5;
   localparam int EVT_W = 3;

   typedef enum logic [1:0] {
      COUNT_UP     = 2'b00,
      COUNT_DOWN   = 2'b01,
      COUNT_UPDOWN = 2'b10
   } count_mode_e;

   // Bit 0 set masks the min event, bit 1 set masks the max event.
   typedef enum logic [1:0] {
      NO_MASK     = 2'b00,
      MIN_MASK    = 2'b01,
      MAX_MASK    = 2'b10,
      MINMAX_MASK = 2'b11
   } mask_mode_e;

   typedef enum logic {
      SW_OFF = 1'b0,
      SW_ON  = 1'b1
   } onoff_e;

   // Direction the carrier reports after landing on 'cnt'. In up-down mode
   // the flag flips as soon as a boundary is reached, otherwise it keeps the
   // direction of the step just taken.
   function automatic logic modeDir(input logic [1:0]       mode,
                                    input logic [CNT_W-1:0] cnt,
                                    input logic [CNT_W-1:0] period,
                                    input logic             moveDir);
      case (mode)
         COUNT_DOWN:   modeDir = 1'b1;
         COUNT_UPDOWN: modeDir = (cnt >= period) ? 1'b1 :
                                 (cnt == '0)     ? 1'b0 : moveDir;
         default:      modeDir = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pwm_carrier_gen_if.sv
// ----------------------------------------------------------------------------
// pwm_carrier_gen_if
// Bundle between the register bank (master) and the carrier generator (slave).
// Config (master -> slave):
//   i_pwm_on, i_carr_on, i_count_mode, i_mask_mode, i_period,
//   i_clkdiv_on, i_clkdiv, i_evt_div, i_int_on
// Status (slave -> master):
//   o_carrier, o_dir, o_evt_min, o_evt_max, o_load, o_int
// ----------------------------------------------------------------------------
interface pwm_carrier_gen_if;
   import pwm_carrier_gen_pkg::*;

   logic             i_pwm_on;
   logic             i_carr_on;
   logic [1:0]       i_count_mode;
   logic [1:0]       i_mask_mode;
   logic [CNT_W-1:0] i_period;
   logic             i_clkdiv_on;
   logic [DIV_W-1:0] i_clkdiv;
   logic [EVT_W-1:0] i_evt_div;
   logic             i_int_on;

   logic [CNT_W-1:0] o_carrier;
   logic             o_dir;
   logic             o_evt_min;
   logic             o_evt_max;
   logic             o_load;
   logic             o_int;

   modport master (
      output i_pwm_on, i_carr_on, i_count_mode, i_mask_mode, i_period,
             i_clkdiv_on, i_clkdiv, i_evt_div, i_int_on,
      input  o_carrier, o_dir, o_evt_min, o_evt_max, o_load, o_int
   );

   modport slave (
      input  i_pwm_on, i_carr_on, i_count_mode, i_mask_mode, i_period,
             i_clkdiv_on, i_clkdiv, i_evt_div, i_int_on,
      output o_carrier, o_dir, o_evt_min, o_evt_max, o_load, o_int
   );

endinterface

// File: rtl/pwm_carrier_gen_clkdiv.sv
// ----------------------------------------------------------------------------
// pwm_carrier_gen_clkdiv
// Prescaler producing the carrier tick.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   enable_i    count / tick allowed (pwm and carrier both on)
//   clear_i     force prescaler to zero (pwm off)
//   divOn_i     prescaler in use; when low every enabled clock ticks
//   div_i       D: tick every D+1 enabled clocks
//   tick_o      one-clock tick pulse (combinational)
// ----------------------------------------------------------------------------
module pwm_carrier_gen_clkdiv
   import pwm_carrier_gen_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable_i,
   input  logic             clear_i,
   input  logic             divOn_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] presc_q, presc_d;
   logic             atTerminal;

   // The terminal test uses >= so that lowering D below the current count
   // wraps at once instead of running all the way round the counter.
   always_comb begin
      atTerminal = (presc_q >= div_i);
      presc_d    = presc_q;
      if (clear_i || !divOn_i) begin
         presc_d = '0;
      end else if (enable_i) begin
         presc_d = atTerminal ? '0 : presc_q + 1'b1;
      end
   end

   assign tick_o = enable_i && !clear_i && (!divOn_i || atTerminal);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

endmodule

// File: rtl/pwm_carrier_gen.sv
// ----------------------------------------------------------------------------
// pwm_carrier_gen
// Carrier counter stage: up / down / up-down carrier from a prescaled tick,
// boundary event pulses, shadow-load strobe and decimated interrupt.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   bus         pwm_carrier_gen_if.slave (config in, carrier/status out)
// ----------------------------------------------------------------------------
module pwm_carrier_gen
   import pwm_carrier_gen_pkg::*;
(
   input logic              clk,
   input logic              rstn,
   pwm_carrier_gen_if.slave bus
);

   logic [1:0]       mode_q, mode_d;
   logic [1:0]       mask_q, mask_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] carrier_q, carrier_d;
   logic             dir_q, dir_d;
   logic             evtMin_q, evtMin_d;
   logic             evtMax_q, evtMax_d;
   logic             load_q, load_d;
   logic             int_q, int_d;
   logic [EVT_W-1:0] evtCount_q, evtCount_d;

   logic             pwmOn;
   logic             tick;
   logic [CNT_W-1:0] nextCnt;
   logic             moveDir;
   logic             hitMin, hitMax, unmasked;
   logic [CNT_W-1:0] startVal;

   assign pwmOn = (bus.i_pwm_on == SW_ON);

   pwm_carrier_gen_clkdiv u_clkdiv (
      .clk      (clk),
      .rstn     (rstn),
      .enable_i (pwmOn && (bus.i_carr_on == SW_ON)),
      .clear_i  (!pwmOn),
      .divOn_i  (bus.i_clkdiv_on == SW_ON),
      .div_i    (bus.i_clkdiv),
      .tick_o   (tick)
   );

   // Candidate next carrier value for a tick under the active mode.
   // moveDir records which way that step actually went so the up-down
   // direction flag can keep it between boundaries.
   always_comb begin
      nextCnt = carrier_q;
      moveDir = dir_q;
      case (mode_q)
         COUNT_DOWN: begin
            moveDir = 1'b1;
            nextCnt = (carrier_q == '0) ? period_q : carrier_q - 1'b1;
         end
         COUNT_UPDOWN: begin
            if (!dir_q) begin
               if (carrier_q >= period_q) begin
                  moveDir = 1'b1;
                  nextCnt = (carrier_q == '0) ? '0 : carrier_q - 1'b1;
               end else begin
                  moveDir = 1'b0;
                  nextCnt = carrier_q + 1'b1;
               end
            end else begin
               if (carrier_q == '0) begin
                  moveDir = 1'b0;
                  nextCnt = (period_q == '0) ? '0 : CNT_W'(1);
               end else begin
                  moveDir = 1'b1;
                  nextCnt = carrier_q - 1'b1;
               end
            end
         end
         default: begin
            moveDir = 1'b0;
            nextCnt = (carrier_q >= period_q) ? '0 : carrier_q + 1'b1;
         end
      endcase
   end

   // Boundary events fire only on the tick that lands on 0 / P, so a value
   // held by the prescaler does not repeat its pulse. Mask bit 0 blocks min,
   // bit 1 blocks max; a simultaneous min+max is still a single event.
   assign hitMin   = tick && (nextCnt == '0);
   assign hitMax   = tick && (nextCnt == period_q);
   assign unmasked = (hitMin && !mask_q[0]) || (hitMax && !mask_q[1]);
   assign startVal = (bus.i_count_mode == COUNT_DOWN) ? bus.i_period : '0;

   // Next-state for the whole carrier stage. With pwm off the shadows are
   // transparent and the carrier sits at its mode's start value; otherwise
   // state only moves on a tick, and an unmasked event copies the shadows
   // and steps the interrupt decimator.
   always_comb begin
      mode_d     = mode_q;
      mask_d     = mask_q;
      period_d   = period_q;
      carrier_d  = carrier_q;
      dir_d      = dir_q;
      evtCount_d = evtCount_q;
      evtMin_d   = 1'b0;
      evtMax_d   = 1'b0;
      load_d     = 1'b0;
      int_d      = 1'b0;
      if (!pwmOn) begin
         mode_d     = bus.i_count_mode;
         mask_d     = bus.i_mask_mode;
         period_d   = bus.i_period;
         carrier_d  = startVal;
         dir_d      = modeDir(bus.i_count_mode, startVal, bus.i_period, 1'b0);
         evtCount_d = '0;
      end else if (tick) begin
         carrier_d = nextCnt;
         evtMin_d  = hitMin;
         evtMax_d  = hitMax;
         if (unmasked) begin
            mode_d   = bus.i_count_mode;
            mask_d   = bus.i_mask_mode;
            period_d = bus.i_period;
            load_d   = 1'b1;
            dir_d    = modeDir(bus.i_count_mode, nextCnt, bus.i_period, moveDir);
            if (evtCount_q == bus.i_evt_div) begin
               evtCount_d = '0;
               int_d      = (bus.i_int_on == SW_ON);
            end else begin
               evtCount_d = evtCount_q + 1'b1;
            end
         end else begin
            dir_d = modeDir(mode_q, nextCnt, period_q, moveDir);
         end
      end
   end

   // State registers; reset leaves the active config at COUNT_UP / NO_MASK / P=0.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mode_q     <= COUNT_UP;
         mask_q     <= NO_MASK;
         period_q   <= '0;
         carrier_q  <= '0;
         dir_q      <= 1'b0;
         evtMin_q   <= 1'b0;
         evtMax_q   <= 1'b0;
         load_q     <= 1'b0;
         int_q      <= 1'b0;
         evtCount_q <= '0;
      end else begin
         mode_q     <= mode_d;
         mask_q     <= mask_d;
         period_q   <= period_d;
         carrier_q  <= carrier_d;
         dir_q      <= dir_d;
         evtMin_q   <= evtMin_d;
         evtMax_q   <= evtMax_d;
         load_q     <= load_d;
         int_q      <= int_d;
         evtCount_q <= evtCount_d;
      end
   end

   assign bus.o_carrier = carrier_q;
   assign bus.o_dir     = dir_q;
   assign bus.o_evt_min = evtMin_q;
   assign bus.o_evt_max = evtMax_q;
   assign bus.o_load    = load_q;
   assign bus.o_int     = int_q;

endmodule
